// File: rtl/izhikevich_integrator.sv
// rtl/izhikevich_integrator.sv - Izhikevich neuron v/w state integrator with one shared multiplier
//
// Purpose
//   Holds the membrane voltage v and recovery variable w of one Izhikevich neuron.
//   Each accepted step applies a precomputed voltage increment dv and advances w
//   by dw = a*(b*v - w)*step. This is a forward Euler update, so dw is computed
//   from the pre-update v and w. A spike occurs when the new v reaches V_TH. On a
//   spike, v is reset to C and w is bumped by D. The three products are
//   time-shared over one multiplier: IDLE -> BV -> AW -> DT -> UPD -> IDLE.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : dv and step are valid
//   in_ready   : high while IDLE; a step is accepted on in_valid && in_ready
//   dv         : voltage increment (already scaled by step), signed Q-format
//   step       : integration timestep, signed Q-format
//   v, w       : state registers, also fed back to the upstream dv calculator
//   spike      : one-cycle pulse alongside out_valid when the neuron fired
//   out_valid  : one-cycle pulse when v, w and spike hold the new step result
//
// Configuration
//   IZH_SATURATE_EN : when defined, every multiply and add result clamps to the
//                     N-bit signed range; otherwise results wrap modulo 2^N.

module izhikevich_integrator #(
    parameter int                     N      = 18,
    parameter int                     Q      = 8,
    parameter logic signed [N-1:0]    A      = 18'sd5,
    parameter logic signed [N-1:0]    B      = 18'sd51,
    parameter logic signed [N-1:0]    C      = -18'sd16640,
    parameter logic signed [N-1:0]    D      = 18'sd2048,
    parameter logic signed [N-1:0]    V_TH   = 18'sd7680,
    parameter logic signed [N-1:0]    W_INIT = -18'sd3315
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [N-1:0]       dv,
    input  logic signed [N-1:0]       step,
    output logic signed [N-1:0]       v,
    output logic signed [N-1:0]       w,
    output logic                      spike,
    output logic                      out_valid
);

    typedef enum logic [2:0] {
        IDLE,
        BV,
        AW,
        DT,
        UPD
    } state_t;

    localparam logic signed [N-1:0] MAX_N = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] MIN_N = {1'b1, {(N-1){1'b0}}};

    // Sign-extend to the 2N-bit working width.
    // Sums and products of two N-bit values cannot overflow at this width.
    function automatic logic signed [2*N-1:0] sext(input logic signed [N-1:0] x);
        return {{N{x[N-1]}}, x};
    endfunction

    // Reduce a 2N-bit intermediate back to N bits (clamp or wrap).
    function automatic logic signed [N-1:0] fit(input logic signed [2*N-1:0] x);
`ifdef IZH_SATURATE_EN
        if (x > sext(MAX_N)) begin
            return MAX_N;
        end else if (x < sext(MIN_N)) begin
            return MIN_N;
        end else begin
            return x[N-1:0];
        end
`else
        return x[N-1:0];
`endif
    endfunction

    state_t                 state_q;
    logic signed [N-1:0]    v_q;
    logic signed [N-1:0]    w_q;
    logic signed [N-1:0]    t_q;      // running product: b*v, then a*(bv-w), then dw
    logic signed [N-1:0]    dv_q;
    logic signed [N-1:0]    step_q;
    logic                   spike_q;
    logic                   out_valid_q;

    logic signed [N-1:0]    op_a;
    logic signed [N-1:0]    op_b;
    logic signed [2*N-1:0]  prod;
    logic signed [2*N-1:0]  prod_sh;
    logic signed [N-1:0]    t_d;      // shared multiplier result
    logic signed [N-1:0]    diff_d;   // b*v - w
    logic signed [N-1:0]    v_d;      // candidate v + dv
    logic signed [N-1:0]    w_d;      // candidate w + dw
    logic signed [N-1:0]    w_bump_d; // candidate w + dw + D, used on a spike
    logic                   fire_d;

    assign diff_d   = fit(sext(t_q) - sext(w_q));
    assign v_d      = fit(sext(v_q) + sext(dv_q));
    assign w_d      = fit(sext(w_q) + sext(t_q));
    assign w_bump_d = fit(sext(w_d) + sext(D));
    assign fire_d   = (v_d >= V_TH);

    // Operand select for the single multiplier. The operands come from the current state.
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (state_q)
            BV: begin
                op_a = B;
                op_b = v_q;
            end
            AW: begin
                op_a = A;
                op_b = diff_d;
            end
            DT: begin
                op_a = t_q;
                op_b = step_q;
            end
            default: begin
                op_a = '0;
                op_b = '0;
            end
        endcase
    end

    // The full-width signed product is shifted right arithmetically by Q.
    // This floors toward minus infinity.
    assign prod    = sext(op_a) * sext(op_b);
    assign prod_sh = prod >>> Q;
    assign t_d     = fit(prod_sh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            v_q         <= C;
            w_q         <= W_INIT;
            t_q         <= '0;
            dv_q        <= '0;
            step_q      <= '0;
            spike_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            spike_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        dv_q    <= dv;
                        step_q  <= step;
                        state_q <= BV;
                    end
                end
                BV: begin
                    t_q     <= t_d;
                    state_q <= AW;
                end
                AW: begin
                    t_q     <= t_d;
                    state_q <= DT;
                end
                DT: begin
                    t_q     <= t_d;
                    state_q <= UPD;
                end
                UPD: begin
                    if (fire_d) begin
                        v_q     <= C;
                        w_q     <= w_bump_d;
                        spike_q <= 1'b1;
                    end else begin
                        v_q     <= v_d;
                        w_q     <= w_d;
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign v         = v_q;
    assign w         = w_q;
    assign spike     = spike_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_izhikevich_integrator.sv
// tb/tb_izhikevich_integrator.sv - self-checking bench for izhikevich_integrator

module tb_izhikevich_integrator;

    localparam int N = 18;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [N-1:0] dv = '0;
    logic signed [N-1:0] step = '0;
    logic signed [N-1:0] v;
    logic signed [N-1:0] w;
    logic                spike;
    logic                out_valid;

    izhikevich_integrator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dv        (dv),
        .step      (step),
        .v         (v),
        .w         (w),
        .spike     (spike),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int ev;
        int ew;
        int es;
        int due;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        bit rst_first;
        int dv;
        int step;
        int ev;
        int ew;
        int es;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out_valid: actual 1, required 0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("out_cycle", cyc, e.due);
                check("out_v", v, e.ev);
                check("out_w", w, e.ew);
                check("out_spike", int'(spike), e.es);
            end
        end else begin
            check("spike_idle", int'(spike), 0);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_v", v, -16640);
        check("rst_w", w, -3315);
        check("rst_spike", int'(spike), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send(input int d, input int s, input int ev, input int ew, input int es);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_send", int'(in_ready), 1);
        in_valid = 1'b1;
        dv       = d[N-1:0];
        step     = s[N-1:0];
        sb.push_back('{ev, ew, es, cyc + 5});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 256, 256, -16384, -3315, 0};
        vecs[1] = '{1'b1, 25600, 256, -16640, -1267, 1};
        vecs[2] = '{1'b1, 24320, 256, -16640, -1267, 1};
`ifdef IZH_SATURATE_EN
        vecs[3] = '{1'b1, -131072, 256, -131072, -3315, 0};
`else
        vecs[3] = '{1'b1, -131072, 256, -16640, -1267, 1};
`endif
        vecs[4] = '{1'b1, 25600, 256, -16640, -1267, 1};
        vecs[5] = '{1'b0, 0, 512, -16640, -1347, 0};
        vecs[6] = '{1'b0, 256, 128, -16384, -1367, 0};
        vecs[7] = '{1'b1, 24319, 256, 7679, -3315, 0};
        vecs[8] = '{1'b0, 1, 256, -16640, -1173, 1};

        repeat (2) @(negedge clk);
        check("rst_init_v", v, -16640);
        check("rst_init_w", w, -3315);
        check("rst_init_in_ready", int'(in_ready), 1);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].rst_first) do_reset();
            send(vecs[i].dv, vecs[i].step, vecs[i].ev, vecs[i].ew, vecs[i].es);
            drain();
        end

        // in_valid held high through the whole step with changing dv
        do_reset();
        @(negedge clk);
        in_valid = 1'b1;
        dv       = 18'sd256;
        step     = 18'sd256;
        sb.push_back('{-16384, -3315, 0, cyc + 5});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("busy_in_ready", int'(in_ready), 0);
            dv   = 18'(1000 * (i + 1));
            step = 18'sd77;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_ready_after", int'(in_ready), 1);
        drain();
        repeat (8) @(negedge clk);

        // reset pulsed while in AW aborts the step
        do_reset();
        @(negedge clk);
        in_valid = 1'b1;
        dv       = 18'sd25600;
        step     = 18'sd256;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_v", v, -16640);
        check("abort_w", w, -3315);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        dv       = 18'sd256;
        step     = 18'sd256;
        sb.push_back('{-16384, -3315, 0, cyc + 5});
        @(negedge clk);
        in_valid = 1'b0;
        drain();
        repeat (6) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
